// File: rtl/cycle_seq.sv
// 6502 per-instruction bus-cycle sequencer: walks the T-states for the decoded
// op_type and decodes address-mux, latch, adder, PC and write strobes from state.
module cycle_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rdy,
  input  logic [4:0] op_type,
  input  logic       st_op,
  input  logic       rmw_op,
  input  logic       carry,
  input  logic       ext_done,
  output logic       sync,
  output logic [2:0] addr_sel,
  output logic       we,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       pc_rel,
  output logic       pc_fix,
  output logic       ld_adl,
  output logic       ld_adh,
  output logic       ld_ptr,
  output logic       add_idx,
  output logic       fix_adh,
  output logic       exec,
  output logic       ext_req,
  output logic       jam
);
  localparam logic [4:0] OP_IMM = 5'd0,  OP_IMP = 5'd1,  OP_BNT = 5'd2,  OP_BRA = 5'd3;
  localparam logic [4:0] OP_ZPG = 5'd4,  OP_ZXY = 5'd5,  OP_ABS = 5'd6,  OP_AXY = 5'd7;
  localparam logic [4:0] OP_JUM = 5'd8,  OP_INY = 5'd9,  OP_XIN = 5'd10, OP_BRK = 5'd11;
  localparam logic [4:0] OP_JSR = 5'd12, OP_RTI = 5'd13, OP_RTS = 5'd14, OP_PUS = 5'd15;
  localparam logic [4:0] OP_PUL = 5'd16, OP_JIN = 5'd17;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_T1, S_IDX, S_ABSH, S_FIX, S_PLO, S_PHI,
    S_DATA, S_RMWR, S_RMWW, S_WR, S_BR, S_BRFIX, S_EXT, S_JAM
  } state_t;

  state_t     state_q;
  logic [4:0] op_q;
  logic [4:0] op_cur;
  state_t     mem_tgt;
  logic       fix_needed;
  logic [2:0] data_sel;
  logic       we_cycle;
  logic       stall;

  // op_type is only valid in T1; later states use the copy latched there.
  always_comb begin
    op_cur     = (state_q == S_T1) ? op_type : op_q;
    mem_tgt    = st_op ? S_WR : (rmw_op ? S_RMWR : S_DATA);
    fix_needed = st_op | rmw_op | carry;
    data_sel   = (op_cur == OP_ZPG || op_cur == OP_ZXY) ? 3'd1 : 3'd2;
    we_cycle   = (state_q == S_RMWW) || (state_q == S_WR);
    stall      = !rdy && !we_cycle && (state_q != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
    end else if (!stall) begin
      case (state_q)
        S_IDLE:  state_q <= S_FETCH;
        S_FETCH: state_q <= S_T1;
        S_T1: begin
          op_q <= op_type;
          case (op_type)
            OP_IMM, OP_IMP, OP_BNT: state_q <= S_FETCH;
            OP_BRA:                 state_q <= S_BR;
            OP_ZPG:                 state_q <= mem_tgt;
            OP_ZXY, OP_XIN:         state_q <= S_IDX;
            OP_ABS, OP_AXY, OP_JUM: state_q <= S_ABSH;
            OP_INY:                 state_q <= S_PLO;
            OP_BRK, OP_JSR, OP_RTI, OP_RTS, OP_PUS, OP_PUL, OP_JIN:
                                    state_q <= S_EXT;
            default:                state_q <= S_JAM;
          endcase
        end
        S_IDX:   state_q <= (op_q == OP_XIN) ? S_PLO : mem_tgt;
        S_ABSH: begin
          if (op_q == OP_JUM)                   state_q <= S_FETCH;
          else if (op_q == OP_AXY && fix_needed) state_q <= S_FIX;
          else                                   state_q <= mem_tgt;
        end
        S_FIX:   state_q <= mem_tgt;
        S_PLO:   state_q <= S_PHI;
        S_PHI:   state_q <= (op_q == OP_INY && fix_needed) ? S_FIX : mem_tgt;
        S_DATA:  state_q <= S_FETCH;
        S_RMWR:  state_q <= S_RMWW;
        S_RMWW:  state_q <= S_WR;
        S_WR:    state_q <= S_FETCH;
        S_BR:    state_q <= carry ? S_BRFIX : S_FETCH;
        S_BRFIX: state_q <= S_FETCH;
        S_EXT:   if (ext_done) state_q <= S_FETCH;
        S_JAM:   state_q <= S_JAM;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    sync = 1'b0; addr_sel = 3'd0; we = 1'b0;
    pc_inc = 1'b0; pc_load = 1'b0; pc_rel = 1'b0; pc_fix = 1'b0;
    ld_adl = 1'b0; ld_adh = 1'b0; ld_ptr = 1'b0; add_idx = 1'b0;
    fix_adh = 1'b0; exec = 1'b0; ext_req = 1'b0; jam = 1'b0;
    case (state_q)
      S_FETCH: begin sync = 1'b1; pc_inc = 1'b1; end
      S_T1: begin
        case (op_type)
          OP_IMM:                 begin pc_inc = 1'b1; exec = 1'b1; end
          OP_IMP:                 exec = 1'b1;
          OP_BNT, OP_BRA:         pc_inc = 1'b1;
          OP_ZPG, OP_ZXY, OP_ABS, OP_AXY, OP_JUM:
                                  begin ld_adl = 1'b1; pc_inc = 1'b1; end
          OP_INY, OP_XIN:         begin ld_ptr = 1'b1; pc_inc = 1'b1; end
          default: ;
        endcase
      end
      S_IDX: begin
        addr_sel = (op_q == OP_XIN) ? 3'd3 : 3'd1;
        add_idx  = 1'b1;
      end
      S_ABSH: begin
        pc_load = (op_q == OP_JUM);
        pc_inc  = (op_q != OP_JUM);
        ld_adh  = (op_q != OP_JUM);
        add_idx = (op_q == OP_AXY);
      end
      S_FIX:   begin addr_sel = 3'd2; fix_adh = carry; end
      S_PLO:   begin addr_sel = 3'd3; ld_adl = 1'b1; end
      S_PHI:   begin addr_sel = 3'd4; ld_adh = 1'b1; add_idx = (op_q == OP_INY); end
      S_DATA:  begin addr_sel = data_sel; exec = 1'b1; end
      S_RMWR:  addr_sel = data_sel;
      S_RMWW:  begin addr_sel = data_sel; we = 1'b1; exec = 1'b1; end
      // The final RMW write-back reuses WR but the ALU result was produced in RMWW.
      S_WR:    begin addr_sel = data_sel; we = 1'b1; exec = !rmw_op; end
      S_BR:    pc_rel = 1'b1;
      S_BRFIX: pc_fix = 1'b1;
      S_EXT:   ext_req = 1'b1;
      S_JAM:   jam = 1'b1;
      default: ;
    endcase
    if (stall) begin
      pc_inc = 1'b0; pc_load = 1'b0; pc_rel = 1'b0; pc_fix = 1'b0;
      ld_adl = 1'b0; ld_adh = 1'b0; ld_ptr = 1'b0; add_idx = 1'b0;
      fix_adh = 1'b0; exec = 1'b0;
    end
  end
endmodule
